// File: rtl/sap_pkg.sv
//==============================================================================
// Module   : sap_pkg
// Brief    : Shared opcodes, control-word bit indices and T-state encodings
// Revision : 1.0
//==============================================================================
`default_nettype none

package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CW_CP  = 11;
    localparam int CW_EP  = 10;
    localparam int CW_NLM = 9;
    localparam int CW_NCE = 8;
    localparam int CW_NLI = 7;
    localparam int CW_NEI = 6;
    localparam int CW_NLA = 5;
    localparam int CW_EA  = 4;
    localparam int CW_SU  = 3;
    localparam int CW_EU  = 2;
    localparam int CW_NLB = 1;
    localparam int CW_NLO = 0;

    localparam logic [11:0] CTRL_NOP = 12'h3E3;

    // Named control words; each is NOP with the relevant lines flipped.
    localparam logic [11:0] CW_FETCH_T1 = 12'h5E3;
    localparam logic [11:0] CW_FETCH_T2 = 12'hBE3;
    localparam logic [11:0] CW_FETCH_T3 = 12'h263;
    localparam logic [11:0] CW_ADDR_LD  = 12'h1A3;
    localparam logic [11:0] CW_RAM_TO_A = 12'h2C3;
    localparam logic [11:0] CW_RAM_TO_B = 12'h2E1;
    localparam logic [11:0] CW_ALU_ADD  = 12'h3C7;
    localparam logic [11:0] CW_ALU_SUB  = 12'h3CF;
    localparam logic [11:0] CW_A_TO_OUT = 12'h3F2;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    function automatic logic is_defined_op(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_OUT) || (op == OP_HLT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sap_ring_counter.sv
//==============================================================================
// Module   : sap_ring_counter
// Brief    : Six-state one-hot T-state ring with hold, freeze and early restart
// Revision : 1.0
//==============================================================================
`default_nettype none

module sap_ring_counter
    import sap_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    input  logic       restart,
    input  logic       freeze,
    output logic [5:0] state
);

    logic [5:0] r_state_q;
    logic [5:0] w_state_d;

    always_comb begin
        w_state_d = r_state_q;
        if (!freeze && advance) begin
            w_state_d = restart ? T1 : {r_state_q[4:0], r_state_q[5]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= T1;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    assign state = r_state_q;

endmodule

`default_nettype wire

// File: rtl/sap_control_sequencer.sv
//==============================================================================
// Module   : sap_control_sequencer
// Brief    : T-state sequencer and opcode decoder producing the 12-bit control word
// Revision : 1.0
//==============================================================================
`default_nettype none

module sap_control_sequencer
    import sap_pkg::*;
#(
    parameter bit SKIP_NOP_T = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_en,
    input  logic [3:0]  opcode,
    output logic [5:0]  t_state,
    output logic        halted,
    output logic [11:0] ctrl_word
);

    logic        r_halted_q;
    logic        w_halted_d;
    logic        w_hlt_now;
    logic        w_restart;
    logic        w_freeze;
    logic [11:0] w_ctrl;
    logic [4:0]  w_drivers;

    // HLT takes effect at the T4 edge even when the ring is otherwise stalled.
    assign w_hlt_now  = !r_halted_q && (t_state == T4) && (opcode == OP_HLT);
    assign w_halted_d = r_halted_q | w_hlt_now;
    assign w_freeze   = w_halted_d;

    always_comb begin
        w_restart = 1'b0;
        if (SKIP_NOP_T) begin
            case (t_state)
                T3:      w_restart = !is_defined_op(opcode);
                T4:      w_restart = (opcode == OP_OUT);
                T5:      w_restart = (opcode == OP_LDA);
                default: w_restart = 1'b0;
            endcase
        end
    end

    sap_ring_counter u_ring (
        .clk     (clk),
        .rst     (rst),
        .advance (step_en),
        .restart (w_restart),
        .freeze  (w_freeze),
        .state   (t_state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted_q <= 1'b0;
        end else begin
            r_halted_q <= w_halted_d;
        end
    end

    always_comb begin
        w_ctrl = CTRL_NOP;
        if (!rst && !r_halted_q) begin
            case (t_state)
                T1: w_ctrl = CW_FETCH_T1;
                T2: w_ctrl = CW_FETCH_T2;
                T3: w_ctrl = CW_FETCH_T3;
                T4: begin
                    if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                        w_ctrl = CW_ADDR_LD;
                    end else if (opcode == OP_OUT) begin
                        w_ctrl = CW_A_TO_OUT;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        w_ctrl = CW_RAM_TO_A;
                    end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                        w_ctrl = CW_RAM_TO_B;
                    end
                end
                T6: begin
                    if (opcode == OP_ADD) begin
                        w_ctrl = CW_ALU_ADD;
                    end else if (opcode == OP_SUB) begin
                        w_ctrl = CW_ALU_SUB;
                    end
                end
                default: w_ctrl = CTRL_NOP;
            endcase
        end
    end

    assign ctrl_word = w_ctrl;
    assign halted    = r_halted_q;

    // Bus contention guard: at most one of the shared-bus drivers enabled.
    assign w_drivers = {w_ctrl[CW_EP], ~w_ctrl[CW_NCE], ~w_ctrl[CW_NEI],
                        w_ctrl[CW_EA], w_ctrl[CW_EU]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($countones(w_drivers) <= 1);
        end
    end

endmodule

`default_nettype wire
